// File: rtl/regfile_wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// The optional bypass compare in the top is enabled by WB_BYPASS_EN.
package regfile_wb_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(0);

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } ptr_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the regfile/read side.
// master = requester/read side, slave = regfile_wb_arbiter.
interface regfile_wb_arbiter_if;
    import regfile_wb_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  stall0_cnt;
    logic [CNT_W-1:0]  stall1_cnt;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              byp_hit_a;
    logic              byp_hit_b;
    logic [DATA_W-1:0] byp_data_a;
    logic [DATA_W-1:0] byp_data_b;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rd_addr_a, rd_addr_b,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data,
        input  stall0_cnt, stall1_cnt,
        input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rd_addr_a, rd_addr_b,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data,
        output stall0_cnt, stall1_cnt,
        output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant with a PRI0/PRI1 pointer FSM.
// Grants are combinational and forced low while rst is high.
module rr_arb2
    import regfile_wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_grant0,
    output logic o_grant1
);

    ptr_state_e r_state;
    logic       w_grant0;
    logic       w_grant1;

    // A lone requester always wins; on contention the pointer decides
    assign w_grant0 = !rst && i_valid0 && (!i_valid1 || (r_state == PRI0));
    assign w_grant1 = !rst && i_valid1 && (!i_valid0 || (r_state == PRI1));

    assign o_grant0 = w_grant0;
    assign o_grant1 = w_grant1;

    // After a transfer, favour the requester that was not served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PRI0;
        end else begin
            case (r_state)
                PRI0: if (w_grant0) r_state <= PRI1;
                PRI1: if (w_grant1) r_state <= PRI0;
                default: r_state <= PRI0;
            endcase
            if (r_state == PRI0 && w_grant1 && !w_grant0) r_state <= PRI0;
            if (r_state == PRI1 && w_grant0 && !w_grant1) r_state <= PRI1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU (req0) and MEM (req1) writebacks.
// Optional forwarding compare against the staged write: define WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    logic              w_grant0;
    logic              w_grant1;
    logic              w_xfer;
    wb_req_t           w_sel;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [CNT_W-1:0]  r_stall0_cnt;
    logic [CNT_W-1:0]  r_stall1_cnt;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .i_valid0 (bus.req0_valid),
        .i_valid1 (bus.req1_valid),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign w_xfer         = w_grant0 || w_grant1;

    always_comb begin
        w_sel.addr = bus.req0_addr;
        w_sel.data = bus.req0_data;
        if (w_grant1) begin
            w_sel.addr = bus.req1_addr;
            w_sel.data = bus.req1_data;
        end
    end

    // Staged write; writes to the zero register are accepted but not enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= ZERO_REG;
            r_wr_data <= DATA_W'(0);
        end else if (w_xfer) begin
            r_wr_en   <= (w_sel.addr != ZERO_REG);
            r_wr_addr <= w_sel.addr;
            r_wr_data <= w_sel.data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall0_cnt <= CNT_W'(0);
            r_stall1_cnt <= CNT_W'(0);
        end else begin
            if (bus.req0_valid && !w_grant0) r_stall0_cnt <= sat_inc(r_stall0_cnt);
            if (bus.req1_valid && !w_grant1) r_stall1_cnt <= sat_inc(r_stall1_cnt);
        end
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.stall0_cnt = r_stall0_cnt;
    assign bus.stall1_cnt = r_stall1_cnt;

`ifdef WB_BYPASS_EN
    // Zero register never hits since r_wr_en is already low for it
    assign bus.byp_hit_a  = r_wr_en && (bus.rd_addr_a == r_wr_addr);
    assign bus.byp_hit_b  = r_wr_en && (bus.rd_addr_b == r_wr_addr);
    assign bus.byp_data_a = r_wr_data;
    assign bus.byp_data_b = r_wr_data;
`else
    logic w_unused_rd;
    assign w_unused_rd    = ^{bus.rd_addr_a, bus.rd_addr_b};
    assign bus.byp_hit_a  = 1'b0;
    assign bus.byp_hit_b  = 1'b0;
    assign bus.byp_data_a = DATA_W'(0);
    assign bus.byp_data_b = DATA_W'(0);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (bypass checks follow WB_BYPASS_EN).
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef WB_BYPASS_EN
    localparam logic       BYP_ON = 1'b1;
`else
    localparam logic       BYP_ON = 1'b0;
`endif

    initial begin
        logic [4:0] exp_addr [4];
        logic       exp_g0   [4];
        exp_addr[0] = 5'd5; exp_addr[1] = 5'd6; exp_addr[2] = 5'd5; exp_addr[3] = 5'd6;
        exp_g0[0]   = 1'b1; exp_g0[1]   = 1'b0; exp_g0[2]   = 1'b1; exp_g0[3]   = 1'b0;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.rd_addr_a  = '0;   bus.rd_addr_b = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset
        step();
        check_eq("rst_wr_en",   32'(bus.wr_en), 32'd0);
        check_eq("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check_eq("rst_wr_data", bus.wr_data, 32'd0);
        check_eq("rst_rdy0",    32'(bus.req0_ready), 32'd0);
        check_eq("rst_rdy1",    32'(bus.req1_ready), 32'd0);
        check_eq("rst_stall0",  32'(bus.stall0_cnt), 32'd0);
        check_eq("rst_stall1",  32'(bus.stall1_cnt), 32'd0);

        // 2: req0 alone
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd2; bus.req0_data = 32'd25;
        #1;
        check_eq("t2_rdy0", 32'(bus.req0_ready), 32'd1);
        check_eq("t2_rdy1", 32'(bus.req1_ready), 32'd0);
        step();
        bus.req0_valid = 1'b0;
        check_eq("t2_wr_en",   32'(bus.wr_en), 32'd1);
        check_eq("t2_wr_addr", 32'(bus.wr_addr), 32'd2);
        check_eq("t2_wr_data", bus.wr_data, 32'd25);
        step();
        check_eq("t2_idle_en",   32'(bus.wr_en), 32'd0);
        check_eq("t2_hold_addr", 32'(bus.wr_addr), 32'd2);
        check_eq("t2_hold_data", bus.wr_data, 32'd25);

        // 4: req1 to $zero is accepted and dropped (also returns pointer to PRI0)
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'd3;
        #1;
        check_eq("t4_rdy1", 32'(bus.req1_ready), 32'd1);
        step();
        bus.req1_valid = 1'b0;
        check_eq("t4_wr_en",   32'(bus.wr_en), 32'd0);
        check_eq("t4_wr_addr", 32'(bus.wr_addr), 32'd0);
        check_eq("t4_wr_data", bus.wr_data, 32'd3);

        // 3: contention alternates 0,1,0,1
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h50;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd6; bus.req1_data = 32'h60;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("t3_rdy0_%0d", i), 32'(bus.req0_ready), 32'(exp_g0[i]));
            check_eq($sformatf("t3_rdy1_%0d", i), 32'(bus.req1_ready), 32'(!exp_g0[i]));
            step();
            check_eq($sformatf("t3_wr_en_%0d", i),   32'(bus.wr_en), 32'd1);
            check_eq($sformatf("t3_wr_addr_%0d", i), 32'(bus.wr_addr), 32'(exp_addr[i]));
            check_eq($sformatf("t3_wr_data_%0d", i), bus.wr_data,
                     exp_g0[i] ? 32'h50 : 32'h60);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check_eq("t3_stall0", 32'(bus.stall0_cnt), 32'd2);
        check_eq("t3_stall1", 32'(bus.stall1_cnt), 32'd2);
        step();
        check_eq("t3_idle_en", 32'(bus.wr_en), 32'd0);

        // 5: bypass compare against a staged write to r5
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'd3;
        step();
        bus.req0_valid = 1'b0;
        bus.rd_addr_a = 5'd5;
        bus.rd_addr_b = 5'd6;
        #1;
        check_eq("t5_wr_en",     32'(bus.wr_en), 32'd1);
        check_eq("t5_hit_a",     32'(bus.byp_hit_a), 32'(BYP_ON));
        check_eq("t5_data_a",    bus.byp_data_a, BYP_ON ? 32'd3 : 32'd0);
        check_eq("t5_hit_b",     32'(bus.byp_hit_b), 32'd0);

        // 6: async reset while a write is staged; pointer (was PRI1) returns to PRI0
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 32'h99;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'h77;
        rst = 1'b1;
        #1;
        check_eq("t6_wr_en",   32'(bus.wr_en), 32'd0);
        check_eq("t6_rdy0",    32'(bus.req0_ready), 32'd0);
        check_eq("t6_rdy1",    32'(bus.req1_ready), 32'd0);
        check_eq("t6_stall0",  32'(bus.stall0_cnt), 32'd0);
        check_eq("t6_stall1",  32'(bus.stall1_cnt), 32'd0);
        check_eq("t6_hit_a",   32'(bus.byp_hit_a), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("t6_ptr_rdy0", 32'(bus.req0_ready), 32'd1);
        check_eq("t6_ptr_rdy1", 32'(bus.req1_ready), 32'd0);
        step();
        check_eq("t6_wr_addr", 32'(bus.wr_addr), 32'd9);
        check_eq("t6_wr_data", bus.wr_data, 32'h99);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
